// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the single external memory bus between instruction
// fetch (IF) and data access (MEM). Each access runs as a req/ack
// transaction with wait states and an abort on timeout. The block also
// drives the pipeline stall vector while an access is outstanding.
//
// Handshake: a requester holds its *_req level until the matching *_ready
// pulse (one cycle). On the bus side, bus_req stays high and bus_* stay
// stable for the whole busy period. A one-cycle bus_ack completes the
// transaction, and bus_rdata is sampled together with bus_ack.
//
// The FSM state is kept in the internal signal 'state' so that checkers can
// bind to it.
module bus_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_inst,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_sel,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_sel,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err,
   output logic [5:0]  stall
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   // The last busy cycle before an abort: the counter reads TIMEOUT-1 there.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             bus_req_d, bus_we_d;
   logic [31:0]      bus_addr_d, bus_wdata_d;
   logic [3:0]       bus_sel_d;
   logic [31:0]      if_inst_d, mem_rdata_d;
   logic             if_ready_d, mem_ready_d, bus_err_d;

   logic mem_go, if_go, cnt_last;

   // A request is still pending during its own ready cycle, because the
   // requester only drops req after it sees ready. Masking with the ready
   // pulse stops a finished request from being granted a second time.
   assign mem_go   = mem_req & ~mem_ready;
   assign if_go    = if_req & ~if_ready;
   assign cnt_last = (cnt == CNT_LAST);

   // State register and all registered outputs. An asynchronous reset
   // abandons any transaction, so bus_req drops without waiting for a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_sel   <= '0;
         if_inst   <= '0;
         mem_rdata <= '0;
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         bus_req   <= bus_req_d;
         bus_we    <= bus_we_d;
         bus_addr  <= bus_addr_d;
         bus_wdata <= bus_wdata_d;
         bus_sel   <= bus_sel_d;
         if_inst   <= if_inst_d;
         mem_rdata <= mem_rdata_d;
         if_ready  <= if_ready_d;
         mem_ready <= mem_ready_d;
         bus_err   <= bus_err_d;
      end
   end

   // Next state. Data wins over fetch because MEM belongs to the older
   // instruction. Serving fetch first could deadlock the pipeline.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (mem_go)
               state_d = MEM_BUSY;
            else if (if_go)
               state_d = IF_BUSY;
         end
         IF_BUSY, MEM_BUSY: begin
            if (bus_ack || cnt_last)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs. The grant is latched onto bus_*
   // and then held. A completion, or an abort, produces a one-cycle ready
   // pulse.
   always_comb begin
      cnt_d       = cnt;
      bus_req_d   = bus_req;
      bus_we_d    = bus_we;
      bus_addr_d  = bus_addr;
      bus_wdata_d = bus_wdata;
      bus_sel_d   = bus_sel;
      if_inst_d   = if_inst;
      mem_rdata_d = mem_rdata;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      bus_err_d   = 1'b0;
      case (state)
         IDLE: begin
            // A stray bus_ack in IDLE is ignored.
            cnt_d = '0;
            if (mem_go) begin
               bus_req_d   = 1'b1;
               bus_we_d    = mem_we;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               bus_sel_d   = mem_sel;
            end else if (if_go) begin
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = if_addr;
               bus_wdata_d = '0;
               bus_sel_d   = 4'b1111;
            end
         end
         IF_BUSY: begin
            if (bus_ack) begin
               bus_req_d  = 1'b0;
               cnt_d      = '0;
               if_inst_d  = bus_rdata;
               if_ready_d = 1'b1;
            end else if (cnt_last) begin
               bus_req_d  = 1'b0;
               cnt_d      = '0;
               if_inst_d  = '0;
               if_ready_d = 1'b1;
               bus_err_d  = 1'b1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         MEM_BUSY: begin
            if (bus_ack) begin
               bus_req_d   = 1'b0;
               cnt_d       = '0;
               if (!bus_we)
                  mem_rdata_d = bus_rdata;
               mem_ready_d = 1'b1;
            end else if (cnt_last) begin
               bus_req_d   = 1'b0;
               cnt_d       = '0;
               mem_rdata_d = '0;
               mem_ready_d = 1'b1;
               bus_err_d   = 1'b1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: begin
            bus_req_d = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   // Stall vector. A data access freezes everything up to MEM. A fetch holds
   // only PC and IF/ID, so later stages drain and IF/ID receives bubbles.
   // Stall is released during the ready cycle itself, and is forced low
   // while reset is asserted.
   always_comb begin
      stall = 6'b000000;
      if (rst) begin
         if (mem_req && !mem_ready)
            stall = 6'b011111;
         else if (if_req && !if_ready)
            stall = 6'b000011;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Expected read data is queued in exp_q when
// a request is driven. It is popped and compared when the matching ready
// pulse appears. Inputs are driven and outputs sampled on the falling edge.
module tb_bus_arbiter;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        if_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_sel;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;
   logic [5:0]  stall;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   logic [31:0] rnd_addr;

   bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_inst   (if_inst),
      .if_ready  (if_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_sel   (mem_sel),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_sel   (bus_sel),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .bus_err   (bus_err),
      .stall     (stall)
   );

   // Clock and reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench hung");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Scoreboard pop, done when a ready pulse is observed
   task automatic sb_pop(input string tag, input logic [31:0] obs);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=%h expected=queue_entry", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         check(tag, obs, exp_v);
      end
   endtask

   initial begin
      int n;
      rst       = 1'b0;
      if_req    = 1'b0;
      if_addr   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_sel   = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
      step();
      step();

      // Reset state
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd0);
      check("rst_mem_ready", 32'(mem_ready), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_if_inst", if_inst, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      rst = 1'b1;
      step();

      // Fetch only, ack in the second busy cycle
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      exp_q.push_back(32'h3C01_0001);
      #1 check("f_stall_req", 32'(stall), 32'b000011);
      step();
      check("f_bus_req", 32'(bus_req), 32'd1);
      check("f_bus_sel", 32'(bus_sel), 32'hF);
      check("f_bus_we", 32'(bus_we), 32'd0);
      check("f_bus_addr", bus_addr, 32'h0000_0100);
      check("f_stall_busy", 32'(stall), 32'b000011);
      check("f_no_early_ready", 32'(if_ready), 32'd0);
      step();
      bus_ack   = 1'b1;
      bus_rdata = 32'h3C01_0001;
      step();
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("f_if_ready", 32'(if_ready), 32'd1);
      sb_pop("f_if_inst", if_inst);
      check("f_stall_ready", 32'(stall), 32'd0);
      check("f_bus_req_drop", 32'(bus_req), 32'd0);
      check("f_mem_ready", 32'(mem_ready), 32'd0);
      if_req = 1'b0;
      step();
      check("f_ready_once", 32'(if_ready), 32'd0);
      check("f_no_regrant", 32'(bus_req), 32'd0);

      // Write, mid-transaction input changes must be ignored
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 32'h0000_0200;
      mem_wdata = 32'hDEAD_BEEF;
      mem_sel   = 4'b0011;
      exp_q.push_back(32'h0);
      #1 check("w_stall_req", 32'(stall), 32'b011111);
      step();
      check("w_bus_req", 32'(bus_req), 32'd1);
      check("w_bus_we", 32'(bus_we), 32'd1);
      check("w_bus_addr", bus_addr, 32'h0000_0200);
      check("w_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      check("w_bus_sel", 32'(bus_sel), 32'b0011);
      check("w_stall_busy", 32'(stall), 32'b011111);
      rnd_addr  = 32'($urandom_range(32'h1000, 32'hFFFF));
      mem_addr  = rnd_addr;
      mem_wdata = 32'h0BAD_0BAD;
      mem_we    = 1'b0;
      step();
      check("w_addr_stable", bus_addr, 32'h0000_0200);
      check("w_wdata_stable", bus_wdata, 32'hDEAD_BEEF);
      check("w_we_stable", 32'(bus_we), 32'd1);
      bus_ack   = 1'b1;
      bus_rdata = 32'hAAAA_5555;
      step();
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("w_mem_ready", 32'(mem_ready), 32'd1);
      sb_pop("w_mem_rdata", mem_rdata);
      check("w_stall_ready", 32'(stall), 32'd0);
      mem_req = 1'b0;
      step();
      check("w_ready_once", 32'(mem_ready), 32'd0);

      // Contention: MEM read first, then fetch after one IDLE cycle
      if_req   = 1'b1;
      if_addr  = 32'h0000_0400;
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = 32'h0000_0300;
      mem_sel  = 4'hF;
      exp_q.push_back(32'h1234_5678);
      exp_q.push_back(32'h0BAD_F00D);
      #1 check("c_stall_both", 32'(stall), 32'b011111);
      step();
      check("c_mem_first", bus_addr, 32'h0000_0300);
      check("c_bus_we", 32'(bus_we), 32'd0);
      check("c_stall_mem", 32'(stall), 32'b011111);
      bus_ack   = 1'b1;
      bus_rdata = 32'h1234_5678;
      step();
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("c_mem_ready", 32'(mem_ready), 32'd1);
      sb_pop("c_mem_rdata", mem_rdata);
      check("c_if_ready_low", 32'(if_ready), 32'd0);
      check("c_idle_gap", 32'(bus_req), 32'd0);
      check("c_stall_if", 32'(stall), 32'b000011);
      mem_req = 1'b0;
      step();
      check("c_if_bus_req", 32'(bus_req), 32'd1);
      check("c_if_bus_addr", bus_addr, 32'h0000_0400);
      check("c_if_bus_sel", 32'(bus_sel), 32'hF);
      check("c_stall_if_busy", 32'(stall), 32'b000011);
      bus_ack   = 1'b1;
      bus_rdata = 32'h0BAD_F00D;
      step();
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("c_if_ready", 32'(if_ready), 32'd1);
      sb_pop("c_if_inst", if_inst);
      check("c_stall_done", 32'(stall), 32'd0);
      check("c_mem_rdata_kept", mem_rdata, 32'h1234_5678);
      if_req = 1'b0;
      step();

      // Timeout: fetch with no ack
      if_req  = 1'b1;
      if_addr = 32'h0000_0500;
      exp_q.push_back(32'h0);
      step();
      n = 0;
      while (bus_req === 1'b1 && n < 40) begin
         n++;
         step();
      end
      check("t_busy_cycles", 32'(n), 32'(TIMEOUT));
      check("t_if_ready", 32'(if_ready), 32'd1);
      check("t_bus_err", 32'(bus_err), 32'd1);
      sb_pop("t_if_inst", if_inst);
      check("t_mem_ready", 32'(mem_ready), 32'd0);
      if_req = 1'b0;
      step();
      check("t_err_once", 32'(bus_err), 32'd0);
      check("t_ready_once", 32'(if_ready), 32'd0);

      // Next request after a timeout completes normally, ack at busy cycle 1
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_addr = 32'h0000_0600;
      exp_q.push_back(32'hCAFE_F00D);
      step();
      check("t2_bus_req", 32'(bus_req), 32'd1);
      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFE_F00D;
      step();
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("t2_mem_ready", 32'(mem_ready), 32'd1);
      sb_pop("t2_mem_rdata", mem_rdata);
      check("t2_no_err", 32'(bus_err), 32'd0);
      mem_req = 1'b0;
      step();

      // Stray ack in IDLE
      bus_ack   = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      step();
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("s_if_ready", 32'(if_ready), 32'd0);
      check("s_mem_ready", 32'(mem_ready), 32'd0);
      check("s_if_inst", if_inst, 32'h0);
      check("s_mem_rdata", mem_rdata, 32'hCAFE_F00D);
      check("s_bus_req", 32'(bus_req), 32'd0);
      step();

      // Reset asserted mid-transaction, between clock edges
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = 32'h0000_0800;
      mem_wdata = 32'h5555_AAAA;
      mem_sel   = 4'hF;
      step();
      check("r_bus_req_before", 32'(bus_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("r_bus_req_async", 32'(bus_req), 32'd0);
      check("r_stall_async", 32'(stall), 32'd0);
      check("r_bus_addr", bus_addr, 32'd0);
      check("r_bus_we", 32'(bus_we), 32'd0);
      check("r_mem_rdata", mem_rdata, 32'd0);
      check("r_if_inst", if_inst, 32'd0);
      mem_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      if_req  = 1'b1;
      if_addr = 32'h0000_0700;
      exp_q.push_back(32'h2402_0005);
      step();
      check("r_fetch_bus_addr", bus_addr, 32'h0000_0700);
      bus_ack   = 1'b1;
      bus_rdata = 32'h2402_0005;
      step();
      bus_ack   = 1'b0;
      bus_rdata = '0;
      check("r_fetch_ready", 32'(if_ready), 32'd1);
      sb_pop("r_fetch_inst", if_inst);
      if_req = 1'b0;
      step();

      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF) and data access (MEM).
- Sequences each transaction over a req/ack handshake with wait states.
- Generates the 6-bit pipeline stall vector that freezes the PC, the IF/ID register and later stages while an access is outstanding.
- Sits between the fetch/MEM stages and the memory bus, alongside the pipeline control logic.

Parameters:
- TIMEOUT, 16: max cycles a transaction waits for bus_ack before abort (≥2).
- CNT_W, 5: width of the wait counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  32  fetch address
- if_inst  out  32  fetched instruction, valid when if_ready
- if_ready  out  1  one-cycle fetch-complete pulse
- mem_req  in  1  data request, level, held until mem_ready
- mem_we  in  1  1=write, 0=read
- mem_addr  in  32  data address
- mem_wdata  in  32  write data
- mem_sel  in  4  byte enables
- mem_rdata  out  32  read data, valid when mem_ready
- mem_ready  out  1  one-cycle data-complete pulse
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write enable
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_sel  out  4  bus byte enables (4'b1111 for fetch)
- bus_ack  in  1  bus completion, one cycle
- bus_rdata  in  32  bus read data, valid with bus_ack
- bus_err  out  1  one-cycle timeout pulse
- stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1=hold

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0. All registered outputs are 0: if_inst, mem_rdata, bus_*, if_ready, mem_ready, bus_err. Any in-flight transaction is abandoned immediately; bus_req drops without waiting for the clock.
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - mem_req=1 → latch mem_we/addr/wdata/sel onto bus_*, bus_req<=1, go MEM_BUSY.
  - else if_req=1 → bus_addr<=if_addr, bus_we<=0, bus_sel<=4'b1111, bus_req<=1, go IF_BUSY.
  - Data has priority: MEM belongs to the older instruction, which prevents deadlock.
- BUSY states:
  - Counter increments each cycle.
  - bus_ack=1: bus_req<=0, counter<=0, go IDLE.
  - MEM read: mem_rdata<=bus_rdata. MEM write: mem_rdata unchanged.
  - IF: if_inst<=bus_rdata.
  - Matching ready pulses high for exactly the next cycle.
- Latency: request seen in IDLE at cycle N; bus_req high from N+1; ack at cycle A gives ready at A+1. Minimum 2 cycles, ack arriving at N+1. One IDLE cycle always separates transactions.
- Timeout: counter reaches TIMEOUT-1 with no ack:
  - bus_req<=0, go IDLE.
  - Matching ready pulses with data register cleared to 0.
  - bus_err pulses concurrently.
- Bus outputs stay stable for the whole BUSY period; requester inputs changing mid-transaction are ignored.
- A requester dropping its req mid-transaction: transaction still completes, ready pulse still issued (harmless).
- A bus_ack arriving in IDLE is ignored.
- stall (combinational):
  - 6'b011111 when mem_req=1 and mem_ready=0.
  - else 6'b000011 when if_req=1 and if_ready=0 (PC and IF held; downstream drains, IF/ID receives bubbles).
  - else 6'b000000.
  - Stall is never asserted during the ready cycle of the access concerned.
- Simultaneous if_req and mem_req in IDLE: MEM served first, IF in the following IDLE pass. stall=011111 until mem_ready, then 000011.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, bus_ack at 2nd busy cycle with rdata=0x3C010001 → bus_sel=4'hF and bus_we=0; if_ready pulses once with if_inst=0x3C010001; stall=000011 until that cycle, then 000000.
- Write: mem_req=1, we=1, addr=0x200, wdata=0xDEADBEEF, sel=4'b0011 → bus mirrors these values; ack → mem_ready pulse, mem_rdata stays 0; stall=011111 while pending.
- Contention: if_req and mem_req (read 0x300, rdata 0x12345678) asserted together → MEM granted first; mem_rdata=0x12345678; one IDLE cycle, then fetch issues; stall sequence 011111 → 000011 → 000000.
- Timeout: TIMEOUT=16, fetch, no ack → bus_req drops after 16 busy cycles; if_ready, bus_err pulse together with if_inst=0; next request accepted normally.
- Reset mid-op: rst low during MEM_BUSY (async, between clock edges) → bus_req, stall and all registered outputs 0 immediately; after release, a fresh fetch completes normally.
- Stray ack: bus_ack=1 in IDLE with rdata=0xFFFFFFFF → no ready pulse; if_inst and mem_rdata unchanged.
